// File: rtl/ntt_pkg.sv
// rtl/ntt_pkg.sv - shared mode encodings and pipeline constants for the NTT butterfly datapath
package ntt_pkg;

  localparam logic MODE_CT = 1'b0;
  localparam logic MODE_GS = 1'b1;

  localparam int BFLY_LATENCY = 3;

endpackage

// File: rtl/ntt_shoup_mulmod.sv
// rtl/ntt_shoup_mulmod.sv - Shoup modular multiply: registered products z, t then combinational reduction
module ntt_shoup_mulmod #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         en,
  input  logic [W-1:0] x,
  input  logic [W-1:0] w,
  input  logic [W-1:0] wp,
  // modulus of the operation currently held in the product registers
  input  logic [W-1:0] q,
  output logic [W-1:0] r
);

  logic [W-1:0] z_d;
  logic [W-1:0] t_d;
  logic [W-1:0] z_q;
  logic [W-1:0] t_q;
  logic [W-1:0] r_raw;

  assign z_d = x * w;
  assign t_d = W'(({{W{1'b0}}, x} * {{W{1'b0}}, wp}) >> W);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      z_q <= '0;
      t_q <= '0;
    end else if (en) begin
      z_q <= z_d;
      t_q <= t_d;
    end
  end

  // Low W bits suffice: the true difference z - t*q lies in [0, 2q).
  assign r_raw = z_q - t_q * q;
  assign r     = (r_raw >= q) ? r_raw - q : r_raw;

endmodule

// File: rtl/ntt_bfly_pipe.sv
// rtl/ntt_bfly_pipe.sv - 3-stage CT/GS NTT butterfly with Shoup twiddle multiply, valid/ready and tag
// Optional macro NTT_BFLY_INV_HALF_EN: scale GS results by 2^-1 mod q in S3 (odd q required).
module ntt_bfly_pipe
  import ntt_pkg::*;
#(
  parameter int W     = 32,
  parameter int TAG_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_mode,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  input  logic [W-1:0]     in_w,
  input  logic [W-1:0]     in_wp,
  input  logic [W-1:0]     in_q,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_a,
  output logic [W-1:0]     out_b,
  output logic [TAG_W-1:0] out_tag
);

  logic             en;

  logic             s1_valid;
  logic             s1_mode;
  logic [W-1:0]     s1_a;
  logic [W-1:0]     s1_b;
  logic [W-1:0]     s1_w;
  logic [W-1:0]     s1_wp;
  logic [W-1:0]     s1_q;
  logic [TAG_W-1:0] s1_tag;

  logic [W-1:0]     s1_x;
  logic [W-1:0]     s1_a_next;

  logic             s2_valid;
  logic             s2_mode;
  logic [W-1:0]     s2_a;
  logic [W-1:0]     s2_q;
  logic [TAG_W-1:0] s2_tag;
  logic [W-1:0]     s2_m;

  logic             s3_valid;
  logic [W-1:0]     res_a;
  logic [W-1:0]     res_b;

  function automatic logic [W-1:0] cond_sub(input logic [W:0] s, input logic [W-1:0] m);
    logic [W:0] d;
    d = s - {1'b0, m};
    return (s >= {1'b0, m}) ? d[W-1:0] : s[W-1:0];
  endfunction

`ifdef NTT_BFLY_INV_HALF_EN
  function automatic logic [W-1:0] half_mod(input logic [W-1:0] x, input logic [W-1:0] m);
    logic [W:0] s;
    s = x[0] ? ({1'b0, x} + {1'b0, m}) : {1'b0, x};
    return s[W:1];
  endfunction
`endif

  // Single global stall: the whole pipe freezes only while S3 is held.
  assign en        = !s3_valid || out_ready;
  assign in_ready  = en;
  assign out_valid = s3_valid;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
      s1_mode  <= MODE_CT;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_w     <= '0;
      s1_wp    <= '0;
      s1_q     <= '0;
      s1_tag   <= '0;
    end else if (en) begin
      s1_valid <= in_valid;
      s1_mode  <= in_mode;
      s1_a     <= in_a;
      s1_b     <= in_b;
      s1_w     <= in_w;
      s1_wp    <= in_wp;
      s1_q     <= in_q;
      s1_tag   <= in_tag;
    end
  end

  // GS pre-adds; CT passes b to the multiplier and a straight through.
  always_comb begin
    s1_x      = s1_b;
    s1_a_next = s1_a;
    if (s1_mode == MODE_GS) begin
      s1_x      = cond_sub({1'b0, s1_a} + {1'b0, s1_q} - {1'b0, s1_b}, s1_q);
      s1_a_next = cond_sub({1'b0, s1_a} + {1'b0, s1_b}, s1_q);
    end
  end

  ntt_shoup_mulmod #(
    .W(W)
  ) u_mulmod (
    .clk    (clk),
    .reset_n(reset_n),
    .en     (en),
    .x      (s1_x),
    .w      (s1_w),
    .wp     (s1_wp),
    .q      (s2_q),
    .r      (s2_m)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s2_valid <= 1'b0;
      s2_mode  <= MODE_CT;
      s2_a     <= '0;
      s2_q     <= '0;
      s2_tag   <= '0;
    end else if (en) begin
      s2_valid <= s1_valid;
      s2_mode  <= s1_mode;
      s2_a     <= s1_a_next;
      s2_q     <= s1_q;
      s2_tag   <= s1_tag;
    end
  end

  always_comb begin
    res_a = cond_sub({1'b0, s2_a} + {1'b0, s2_m}, s2_q);
    res_b = cond_sub({1'b0, s2_a} + {1'b0, s2_q} - {1'b0, s2_m}, s2_q);
    if (s2_mode == MODE_GS) begin
`ifdef NTT_BFLY_INV_HALF_EN
      res_a = half_mod(s2_a, s2_q);
      res_b = half_mod(s2_m, s2_q);
`else
      res_a = s2_a;
      res_b = s2_m;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s3_valid <= 1'b0;
      out_a    <= '0;
      out_b    <= '0;
      out_tag  <= '0;
    end else if (en) begin
      s3_valid <= s2_valid;
      out_a    <= res_a;
      out_b    <= res_b;
      out_tag  <= s2_tag;
    end
  end

endmodule
